accum_table_rd_seq: RTL and testbench
=====================================

Name: accum_table_rd_seq

Overview:
Sequencing read controller for the accumulator table. It replaces per-cycle external address generation for table reads. On a start command for one output sub-matrix (tile), it walks the tile's sub-rows and issues per-column read enables and addresses for all SYS_ARR_COLS lanes. Controls: per-lane column mask, partial row count, stall backpressure, and an optional diagonal skew that matches systolic-array column timing. It sits between the tile scheduler and the accumulator-table read ports.

Parameters:
MAX_OUT_ROWS, 128, max output matrix rows
MAX_OUT_COLS, 128, max output matrix columns
SYS_ARR_ROWS, 16, systolic array rows (sub-rows per tile)
SYS_ARR_COLS, 16, systolic array columns (read lanes)
Derived: NUM_ROW_SUB_MAT=MAX_OUT_ROWS/SYS_ARR_ROWS; NUM_COL_SUB_MAT=MAX_OUT_COLS/SYS_ARR_COLS; NUM_ACCUM_ROWS=MAX_OUT_ROWS*NUM_COL_SUB_MAT; ADDR_W=$clog2(NUM_ACCUM_ROWS); CNT_W=$clog2(SYS_ARR_ROWS+1)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  tile read request; accepted only when busy=0
submat_row_idx  in  $clog2(NUM_ROW_SUB_MAT)  tile row index, captured on accept
submat_col_idx  in  $clog2(NUM_COL_SUB_MAT)  tile column index, captured on accept
num_rows  in  CNT_W  valid sub-rows in tile, captured on accept
col_en  in  SYS_ARR_COLS  per-lane enable mask, captured on accept
stall  in  1  downstream backpressure
busy  out  1  sequence in progress
done  out  1  one-cycle completion pulse
rd_en  out  SYS_ARR_COLS  per-lane read enable
rd_addr  out  ADDR_W*SYS_ARR_COLS  per-lane address; lane c occupies bits [c*ADDR_W +: ADDR_W]

Behaviour:
- Reset: all outputs 0, FSM in IDLE, counters 0. Reset may assert mid-sequence; the sequence is then abandoned with no done pulse.
- Address of sub-row r: submat_col_idx*MAX_OUT_ROWS + submat_row_idx*SYS_ARR_ROWS + r, computed at ADDR_W bits. The value is the same for every lane; rd_addr of a lane whose rd_en=0 is don't-care but held stable.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE: when start=1 at a clock edge, capture the inputs. Go to ISSUE, or to DONE if num_rows==0 or col_en==0. busy rises next cycle.
- num_rows > SYS_ARR_ROWS is clamped to SYS_ARR_ROWS.
- ISSUE: registered outputs. At each edge where stall=0, issue sub-row r: rd_en=col_en (lane gating) and rd_addr is the address of r on the next cycle; r then increments.
- First issue appears the cycle after the accepting edge, so latency is 1.
- After r=num_rows-1 is issued: go to DRAIN if skew is enabled, else DONE.
- Stall: at any edge where stall=1, the next cycle has rd_en=0, r holds, and addresses hold. No read is duplicated or dropped.
- DRAIN (skew only): flush the lane delay line; stall freezes it likewise. Go to DONE when the line is empty.
- DONE: done=1 for one cycle, busy=0 in that same cycle, then IDLE. start is accepted in IDLE only; start during busy or DONE is ignored.
- Non-skew sequence with no stalls: busy high for num_rows cycles, then done the following cycle.

Optional Feature:
ACCUM_RD_SKEW_EN
- Defined: lane c output is delayed by c cycles through a per-lane shift pipeline (rd_en and rd_addr), so lane c reads sub-row r in cycle 1+r+c. DRAIN lasts SYS_ARR_COLS-1 unstalled cycles. stall=1 freezes every pipeline stage and forces all rd_en to 0 for that cycle.
- Undefined: all lanes issue in the same cycle, no DRAIN state logic and no pipeline registers are built.

Test Plan:
- Defaults, no skew: start with row_idx=2, col_idx=3, num_rows=16, col_en=16'hFFFF. Required: rd_en=16'hFFFF on cycles 1..16 with every lane addr=416..431, done on cycle 17, busy on cycles 1..16.
- Partial tile: num_rows=5, col_en=16'h00F0. Required: only lanes 4..7 enabled, 5 issues at addr base+0..4, done on cycle 6. num_rows=0 -> done on cycle 1, no rd_en.
- Stall: stall=1 at edges 3 and 4 during a 16-row tile. Required: rd_en=0 on cycles 4 and 5, addr 419 issued on cycle 6, every address issued exactly once, done on cycle 19.
- Start ignored: start pulsed again on cycle 8 with different indices. Required: no change to the running sequence, no second done. Async reset on cycle 7: all outputs 0 immediately and no done.
- Skew (ACCUM_RD_SKEW_EN): row_idx=0, col_idx=0, num_rows=2, all lanes. Required: lane 0 reads addr 0,1 on cycles 1,2; lane 15 reads 0,1 on cycles 16,17; done on cycle 18.
- Max indices: row_idx=7, col_idx=7. Required: addr 1008..1023 with no overflow.

Source files
------------

// File: rtl/accum_table_rd_seq.sv
// Accumulator-table read sequencer: walks one tile's sub-rows and drives per-lane read enables and addresses.
// Define ACCUM_RD_SKEW_EN to build the per-lane diagonal skew pipeline and the DRAIN phase.
module accum_table_rd_seq #(
  parameter int MAX_OUT_ROWS = 128,
  parameter int MAX_OUT_COLS = 128,
  parameter int SYS_ARR_ROWS = 16,
  parameter int SYS_ARR_COLS = 16,
  localparam int NUM_ROW_SUB_MAT = MAX_OUT_ROWS / SYS_ARR_ROWS,
  localparam int NUM_COL_SUB_MAT = MAX_OUT_COLS / SYS_ARR_COLS,
  localparam int NUM_ACCUM_ROWS  = MAX_OUT_ROWS * NUM_COL_SUB_MAT,
  localparam int ADDR_W = $clog2(NUM_ACCUM_ROWS),
  localparam int CNT_W  = $clog2(SYS_ARR_ROWS + 1),
  localparam int RI_W   = (NUM_ROW_SUB_MAT > 1) ? $clog2(NUM_ROW_SUB_MAT) : 1,
  localparam int CI_W   = (NUM_COL_SUB_MAT > 1) ? $clog2(NUM_COL_SUB_MAT) : 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [RI_W-1:0]                submat_row_idx,
  input  logic [CI_W-1:0]                submat_col_idx,
  input  logic [CNT_W-1:0]               num_rows,
  input  logic [SYS_ARR_COLS-1:0]        col_en,
  input  logic                           stall,
  output logic                           busy,
  output logic                           done,
  output logic [SYS_ARR_COLS-1:0]        rd_en,
  output logic [ADDR_W*SYS_ARR_COLS-1:0] rd_addr
);

`ifdef ACCUM_RD_SKEW_EN
  localparam int PIPE_N = SYS_ARR_COLS;
  localparam int DR_W   = (SYS_ARR_COLS > 2) ? $clog2(SYS_ARR_COLS) : 1;
`else
  localparam int PIPE_N = 1;
`endif

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t                          state_q, state_d;
  logic [CNT_W-1:0]                cnt_q, nrows_q, nrows_in;
  logic [ADDR_W-1:0]               base_q, base_in, issue_addr;
  logic [SYS_ARR_COLS-1:0]         col_en_q;
  logic                            stalled_q, issue;
  logic [PIPE_N-1:0]               pen;
  logic [PIPE_N-1:0][ADDR_W-1:0]   paddr;

  assign base_in  = ADDR_W'(submat_col_idx) * ADDR_W'(MAX_OUT_ROWS)
                  + ADDR_W'(submat_row_idx) * ADDR_W'(SYS_ARR_ROWS);
  assign nrows_in = (num_rows > CNT_W'(SYS_ARR_ROWS)) ? CNT_W'(SYS_ARR_ROWS) : num_rows;

`ifdef ACCUM_RD_SKEW_EN
  logic [DR_W-1:0] drain_q;
  logic            drain_last;
  assign drain_last = (drain_q == DR_W'(SYS_ARR_COLS - 2));
`endif

  always_comb begin
    state_d    = state_q;
    issue      = 1'b0;
    issue_addr = base_q + ADDR_W'(cnt_q);
    case (state_q)
      IDLE: if (start) begin
        issue_addr = base_in;
        if (nrows_in == '0 || col_en == '0) state_d = DONE;
        else begin
          state_d = ISSUE;
          issue   = ~stall;
        end
      end
      ISSUE: begin
        if (cnt_q == nrows_q) begin
`ifdef ACCUM_RD_SKEW_EN
          state_d = DRAIN;
`else
          state_d = DONE;
`endif
        end else issue = ~stall;
      end
`ifdef ACCUM_RD_SKEW_EN
      DRAIN: if (!stall && drain_last) state_d = DONE;
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      nrows_q   <= '0;
      base_q    <= '0;
      col_en_q  <= '0;
      stalled_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      stalled_q <= stall;
      if (state_q == IDLE && start) begin
        base_q   <= base_in;
        nrows_q  <= nrows_in;
        col_en_q <= col_en;
        cnt_q    <= issue ? CNT_W'(1) : '0;
      end else if (issue) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  // Stage 0 is the issue register; deeper stages only exist for skew. A stalled
  // edge freezes everything and stalled_q blanks the following cycle's enables.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pen   <= '0;
      paddr <= '0;
    end else if (!stall) begin
      pen[0] <= issue;
      if (issue) paddr[0] <= issue_addr;
`ifdef ACCUM_RD_SKEW_EN
      for (int s = 1; s < PIPE_N; s++) begin
        pen[s]   <= pen[s-1];
        paddr[s] <= paddr[s-1];
      end
`endif
    end
  end

`ifdef ACCUM_RD_SKEW_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         drain_q <= '0;
    else if (state_q != DRAIN)          drain_q <= '0;
    else if (!stall && !drain_last)     drain_q <= drain_q + DR_W'(1);
  end
`endif

  for (genvar c = 0; c < SYS_ARR_COLS; c++) begin : g_lane
`ifdef ACCUM_RD_SKEW_EN
    localparam int S = c;
`else
    localparam int S = 0;
`endif
    assign rd_en[c]                   = pen[S] & col_en_q[c] & ~stalled_q;
    assign rd_addr[c*ADDR_W +: ADDR_W] = paddr[S];
  end

  assign busy = (state_q == ISSUE) || (state_q == DRAIN);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_accum_table_rd_seq.sv
// Directed bench for accum_table_rd_seq with hand-computed cycle-by-cycle expectations.
module tb_accum_table_rd_seq;
  localparam int AW   = 10;
  localparam int COLS = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [2:0]        submat_row_idx, submat_col_idx;
  logic [4:0]        num_rows;
  logic [COLS-1:0]   col_en;
  logic              stall;
  logic              busy, done;
  logic [COLS-1:0]   rd_en;
  logic [AW*COLS-1:0] rd_addr;

  int n_checks = 0;
  int n_fail   = 0;

  logic [COLS-1:0]    o_en   [0:63];
  logic [AW*COLS-1:0] o_addr [0:63];
  logic               o_busy [0:63];
  logic               o_done [0:63];

  accum_table_rd_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .submat_row_idx(submat_row_idx), .submat_col_idx(submat_col_idx),
    .num_rows(num_rows), .col_en(col_en), .stall(stall),
    .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr)
  );

  always #5 clk = ~clk;

  function automatic logic [AW-1:0] lane(input logic [AW*COLS-1:0] a, input int c);
    return a[c*AW +: AW];
  endfunction

  // Accepting edge is edge 0; o_*[k] holds the outputs seen during cycle k (after edge k-1).
  task automatic run_seq(input logic [2:0] ri, input logic [2:0] ci, input logic [4:0] nr,
                         input logic [COLS-1:0] ce, input logic [63:0] sm, input int ncyc,
                         input int rs);
    @(negedge clk);
    start = 1'b1; submat_row_idx = ri; submat_col_idx = ci; num_rows = nr; col_en = ce;
    stall = sm[0];
    @(posedge clk);
    for (int cyc = 1; cyc <= ncyc; cyc++) begin
      @(negedge clk);
      o_en[cyc] = rd_en; o_addr[cyc] = rd_addr; o_busy[cyc] = busy; o_done[cyc] = done;
      stall = sm[cyc];
      if (cyc == rs) begin
        start = 1'b1; submat_row_idx = 3'd5; submat_col_idx = 3'd1; num_rows = 5'd3;
      end else start = 1'b0;
      @(posedge clk);
    end
    @(negedge clk);
    start = 1'b0; stall = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; stall = 1'b0;
    submat_row_idx = '0; submat_col_idx = '0; num_rows = '0; col_en = '0;
    #12;
    n_checks++; if (rd_en !== '0)   begin n_fail++; $display("FAIL reset_rd_en got %h want 0", rd_en); end
    n_checks++; if (rd_addr !== '0) begin n_fail++; $display("FAIL reset_rd_addr got %h want 0", rd_addr); end
    n_checks++; if (busy !== 1'b0)  begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (done !== 1'b0)  begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if ({busy, done, rd_en} !== '0)
      begin n_fail++; $display("FAIL idle_after_reset got %b%b %h want all 0", busy, done, rd_en); end
  endtask

`ifndef ACCUM_RD_SKEW_EN
  task automatic test_full_tile;
    run_seq(3'd2, 3'd3, 5'd16, 16'hFFFF, 64'd0, 19, -1);
    for (int cyc = 1; cyc <= 19; cyc++) begin
      n_checks++; if (o_en[cyc] !== ((cyc <= 16) ? 16'hFFFF : 16'h0))
        begin n_fail++; $display("FAIL full_en cyc %0d got %h", cyc, o_en[cyc]); end
      n_checks++; if (o_busy[cyc] !== (cyc <= 16))
        begin n_fail++; $display("FAIL full_busy cyc %0d got %b", cyc, o_busy[cyc]); end
      n_checks++; if (o_done[cyc] !== (cyc == 17))
        begin n_fail++; $display("FAIL full_done cyc %0d got %b", cyc, o_done[cyc]); end
      if (cyc <= 16)
        for (int c = 0; c < COLS; c++) begin
          n_checks++; if (lane(o_addr[cyc], c) !== AW'(416 + cyc - 1))
            begin n_fail++; $display("FAIL full_addr cyc %0d lane %0d got %0d want %0d", cyc, c, lane(o_addr[cyc], c), 416 + cyc - 1); end
        end
    end
  endtask

  task automatic test_partial;
    run_seq(3'd2, 3'd3, 5'd5, 16'h00F0, 64'd0, 8, -1);
    for (int cyc = 1; cyc <= 8; cyc++) begin
      n_checks++; if (o_en[cyc] !== ((cyc <= 5) ? 16'h00F0 : 16'h0))
        begin n_fail++; $display("FAIL part_en cyc %0d got %h", cyc, o_en[cyc]); end
      n_checks++; if (o_done[cyc] !== (cyc == 6))
        begin n_fail++; $display("FAIL part_done cyc %0d got %b", cyc, o_done[cyc]); end
      if (cyc <= 5)
        for (int c = 4; c < 8; c++) begin
          n_checks++; if (lane(o_addr[cyc], c) !== AW'(416 + cyc - 1))
            begin n_fail++; $display("FAIL part_addr cyc %0d lane %0d got %0d", cyc, c, lane(o_addr[cyc], c)); end
        end
    end
    // Empty tile: zero rows, then zero lane mask
    for (int k = 0; k < 2; k++) begin
      run_seq(3'd2, 3'd3, (k == 0) ? 5'd0 : 5'd4, (k == 0) ? 16'hFFFF : 16'h0, 64'd0, 3, -1);
      n_checks++; if ({o_done[1], o_busy[1], o_en[1]} !== {1'b1, 1'b0, 16'h0})
        begin n_fail++; $display("FAIL empty%0d_c1 got done=%b busy=%b en=%h want 1 0 0", k, o_done[1], o_busy[1], o_en[1]); end
      n_checks++; if ({o_done[2], o_busy[2], o_en[2]} !== '0)
        begin n_fail++; $display("FAIL empty%0d_c2 got done=%b busy=%b en=%h want 0", k, o_done[2], o_busy[2], o_en[2]); end
    end
    // num_rows above the tile height clamps to 16
    run_seq(3'd0, 3'd0, 5'd20, 16'hFFFF, 64'd0, 19, -1);
    n_checks++; if (o_en[16] !== 16'hFFFF || lane(o_addr[16], 0) !== AW'(15))
      begin n_fail++; $display("FAIL clamp_last got en=%h addr=%0d want FFFF 15", o_en[16], lane(o_addr[16], 0)); end
    n_checks++; if (o_en[17] !== 16'h0 || o_done[17] !== 1'b1)
      begin n_fail++; $display("FAIL clamp_done got en=%h done=%b want 0 1", o_en[17], o_done[17]); end
  endtask

  task automatic test_stall;
    int nxt;
    run_seq(3'd2, 3'd3, 5'd16, 16'hFFFF, 64'h18, 22, -1);
    n_checks++; if (o_en[4] !== '0 || o_en[5] !== '0)
      begin n_fail++; $display("FAIL stall_gap got %h %h want 0 0", o_en[4], o_en[5]); end
    n_checks++; if (o_en[6] !== 16'hFFFF || lane(o_addr[6], 0) !== AW'(419))
      begin n_fail++; $display("FAIL stall_resume got en=%h addr=%0d want FFFF 419", o_en[6], lane(o_addr[6], 0)); end
    nxt = 416;
    for (int cyc = 1; cyc <= 22; cyc++) begin
      if (o_en[cyc] !== '0) begin
        n_checks++; if (o_en[cyc] !== 16'hFFFF || lane(o_addr[cyc], 0) !== AW'(nxt) || lane(o_addr[cyc], 15) !== AW'(nxt))
          begin n_fail++; $display("FAIL stall_seq cyc %0d got en=%h addr=%0d want %0d", cyc, o_en[cyc], lane(o_addr[cyc], 0), nxt); end
        nxt++;
      end
      n_checks++; if (o_done[cyc] !== (cyc == 19))
        begin n_fail++; $display("FAIL stall_done cyc %0d got %b", cyc, o_done[cyc]); end
    end
    n_checks++; if (nxt !== 432)
      begin n_fail++; $display("FAIL stall_count got %0d issues want 16", nxt - 416); end
  endtask

  task automatic test_start_ignored;
    int ndone;
    run_seq(3'd2, 3'd3, 5'd16, 16'hFFFF, 64'd0, 30, 8);
    ndone = 0;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      if (o_done[cyc] === 1'b1) ndone++;
      if (cyc <= 16) begin
        n_checks++; if (o_en[cyc] !== 16'hFFFF || lane(o_addr[cyc], 3) !== AW'(416 + cyc - 1))
          begin n_fail++; $display("FAIL ign_seq cyc %0d got en=%h addr=%0d", cyc, o_en[cyc], lane(o_addr[cyc], 3)); end
      end else begin
        n_checks++; if (o_en[cyc] !== '0 || o_busy[cyc] !== 1'b0)
          begin n_fail++; $display("FAIL ign_after cyc %0d got en=%h busy=%b want idle", cyc, o_en[cyc], o_busy[cyc]); end
      end
    end
    n_checks++; if (ndone !== 1 || o_done[17] !== 1'b1)
      begin n_fail++; $display("FAIL ign_done got %0d pulses want 1 at cycle 17", ndone); end
  endtask

  task automatic test_async_reset;
    int ndone;
    @(negedge clk);
    start = 1'b1; submat_row_idx = 3'd2; submat_col_idx = 3'd3; num_rows = 5'd16; col_en = 16'hFFFF;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    n_checks++; if (rd_en !== 16'hFFFF || lane(rd_addr, 0) !== AW'(422))
      begin n_fail++; $display("FAIL arst_pre got en=%h addr=%0d want FFFF 422", rd_en, lane(rd_addr, 0)); end
    #1; rst_n = 1'b0; #1;
    n_checks++; if ({busy, done, rd_en, rd_addr} !== '0)
      begin n_fail++; $display("FAIL arst_now got busy=%b done=%b en=%h addr=%h want 0", busy, done, rd_en, rd_addr); end
    ndone = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done === 1'b1 || rd_en !== '0 || busy === 1'b1) ndone++;
    end
    n_checks++; if (ndone !== 0)
      begin n_fail++; $display("FAIL arst_after got %0d active cycles want 0", ndone); end
  endtask

  task automatic test_max_idx;
    run_seq(3'd7, 3'd7, 5'd16, 16'hFFFF, 64'd0, 17, -1);
    for (int cyc = 1; cyc <= 16; cyc++) begin
      n_checks++; if (lane(o_addr[cyc], 0) !== AW'(1007 + cyc) || lane(o_addr[cyc], 15) !== AW'(1007 + cyc))
        begin n_fail++; $display("FAIL max_addr cyc %0d got %0d want %0d", cyc, lane(o_addr[cyc], 0), 1007 + cyc); end
    end
    n_checks++; if (o_done[17] !== 1'b1)
      begin n_fail++; $display("FAIL max_done got %b want 1", o_done[17]); end
  endtask
`else
  task automatic test_skew;
    int r;
    run_seq(3'd0, 3'd0, 5'd2, 16'hFFFF, 64'd0, 20, -1);
    for (int cyc = 1; cyc <= 20; cyc++) begin
      for (int c = 0; c < COLS; c++) begin
        r = cyc - 1 - c;
        n_checks++; if (o_en[cyc][c] !== (r == 0 || r == 1))
          begin n_fail++; $display("FAIL skew_en cyc %0d lane %0d got %b", cyc, c, o_en[cyc][c]); end
        if (r == 0 || r == 1) begin
          n_checks++; if (lane(o_addr[cyc], c) !== AW'(r))
            begin n_fail++; $display("FAIL skew_addr cyc %0d lane %0d got %0d want %0d", cyc, c, lane(o_addr[cyc], c), r); end
        end
      end
      n_checks++; if (o_done[cyc] !== (cyc == 18) || o_busy[cyc] !== (cyc <= 17))
        begin n_fail++; $display("FAIL skew_ctl cyc %0d got done=%b busy=%b", cyc, o_done[cyc], o_busy[cyc]); end
    end
  endtask
`endif

  initial begin
    test_reset();
`ifndef ACCUM_RD_SKEW_EN
    test_full_tile();
    test_partial();
    test_stall();
    test_start_ignored();
    test_async_reset();
    test_max_idx();
`else
    test_skew();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
